// File: rtl/screen_handoff_if.sv
// Pixel-source and VGA write-port bundle shared by the renderers, the hand-off block and the adapter.
// The slave modport is the hand-off block's view of the bundle.
interface screen_handoff_if;
    logic       game_over;
    logic       game_plot;
    logic [7:0] game_x;
    logic [6:0] game_y;
    logic [2:0] game_colour;
    logic       end_plot;
    logic [7:0] end_x;
    logic [6:0] end_y;
    logic [2:0] end_colour;
    logic       end_finish;
    logic       end_en;
    logic       vga_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       done;

    modport master (
        output game_over, game_plot, game_x, game_y, game_colour,
        output end_plot, end_x, end_y, end_colour, end_finish,
        input  end_en, vga_plot, vga_x, vga_y, vga_colour, done
    );

    modport slave (
        input  game_over, game_plot, game_x, game_y, game_colour,
        input  end_plot, end_x, end_y, end_colour, end_finish,
        output end_en, vga_plot, vga_x, vga_y, vga_colour, done
    );
endinterface

// File: rtl/screen_handoff.sv
// Owns the VGA write port: forwards game pixels, blanks the screen after game over,
// then hands the port to the end-screen drawer until it reports finish.
module screen_handoff #(
    parameter int       SCREEN_W     = 160,
    parameter int       SCREEN_H     = 120,
    parameter bit [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic               clock,
    input  logic               resetn,
    screen_handoff_if.slave    bus
);
    localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

    typedef enum logic [1:0] {
        ST_GAME   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_ENDSCR = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cx_q, cx_d;
    logic [6:0] cy_q, cy_d;
    logic       plot_q, plot_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] col_q, col_d;
    logic       end_en_q, end_en_d;
    logic       done_q, done_d;

    // Next-state, sweep counters and next registered outputs.
    always_comb begin
        state_d  = state_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        plot_d   = 1'b0;
        x_d      = x_q;
        y_d      = y_q;
        col_d    = col_q;
        end_en_d = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            ST_GAME: begin
                plot_d = bus.game_plot;
                x_d    = bus.game_x;
                y_d    = bus.game_y;
                col_d  = bus.game_colour;
                if (bus.game_over) begin
                    state_d = ST_CLEAR;
                    cx_d    = 8'd0;
                    cy_d    = 7'd0;
                end else begin
                    state_d = ST_GAME;
                end
            end
            ST_CLEAR: begin
                plot_d = 1'b1;
                x_d    = cx_q;
                y_d    = cy_q;
                col_d  = CLEAR_COLOUR;
                if (cx_q == X_LAST) begin
                    cx_d = 8'd0;
                    if (cy_q == Y_LAST) begin
                        cy_d    = 7'd0;
                        state_d = ST_ENDSCR;
                    end else begin
                        cy_d = cy_q + 7'd1;
                    end
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end
            ST_ENDSCR: begin
                end_en_d = 1'b1;
                x_d      = bus.end_x;
                y_d      = bus.end_y;
                col_d    = bus.end_colour;
                // The finishing cycle's strobe is dropped so done and a write never coincide.
                if (bus.end_finish) begin
                    plot_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    plot_d = bus.end_plot;
                end
            end
            ST_DONE: begin
                end_en_d = 1'b1;
                done_d   = 1'b1;
            end
            default: begin
                state_d = ST_GAME;
            end
        endcase
    end

    // State, counters and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_GAME;
            cx_q     <= 8'd0;
            cy_q     <= 7'd0;
            plot_q   <= 1'b0;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            col_q    <= 3'd0;
            end_en_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            plot_q   <= plot_d;
            x_q      <= x_d;
            y_q      <= y_d;
            col_q    <= col_d;
            end_en_q <= end_en_d;
            done_q   <= done_d;
        end
    end

    assign bus.vga_plot   = plot_q;
    assign bus.vga_x      = x_q;
    assign bus.vga_y      = y_q;
    assign bus.vga_colour = col_q;
    assign bus.end_en     = end_en_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_screen_handoff.sv
// Randomised bench for screen_handoff against a pixel-index reference model of the hand-off sequence.
module tb_screen_handoff;
    localparam int W = 160;
    localparam int H = 120;

    logic clock;
    logic resetn;
    int   n_cmp;
    int   n_err;

    screen_handoff_if bus ();

    screen_handoff #(.SCREEN_W(W), .SCREEN_H(H), .CLEAR_COLOUR(3'b000)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: 0 playing, 1 blanking, 2 end screen, 3 finished; m_k is the raster pixel index.
    int m_mode;
    int m_k;
    int exp_plot, exp_x, exp_y, exp_col, exp_en, exp_done;

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            if (n_err <= 20)
                $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_k = 0;
        exp_plot = 0; exp_x = 0; exp_y = 0; exp_col = 0; exp_en = 0; exp_done = 0;
    endtask

    task automatic model_step();
        case (m_mode)
            0: begin
                exp_plot = int'(bus.game_plot); exp_x = int'(bus.game_x);
                exp_y = int'(bus.game_y); exp_col = int'(bus.game_colour);
                exp_en = 0; exp_done = 0;
                if (bus.game_over) begin m_mode = 1; m_k = 0; end
            end
            1: begin
                exp_plot = 1; exp_x = m_k % W; exp_y = m_k / W; exp_col = 0;
                exp_en = 0; exp_done = 0;
                m_k++;
                if (m_k == W * H) m_mode = 2;
            end
            2: begin
                exp_en = 1; exp_x = int'(bus.end_x); exp_y = int'(bus.end_y);
                exp_col = int'(bus.end_colour);
                if (bus.end_finish) begin
                    exp_plot = 0; exp_done = 1; m_mode = 3;
                end else begin
                    exp_plot = int'(bus.end_plot); exp_done = 0;
                end
            end
            default: begin
                exp_plot = 0; exp_en = 1; exp_done = 1;
            end
        endcase
    endtask

    task automatic check_outputs();
        chk("vga_plot",   int'(bus.vga_plot),   exp_plot);
        chk("vga_x",      int'(bus.vga_x),      exp_x);
        chk("vga_y",      int'(bus.vga_y),      exp_y);
        chk("vga_colour", int'(bus.vga_colour), exp_col);
        chk("end_en",     int'(bus.end_en),     exp_en);
        chk("done",       int'(bus.done),       exp_done);
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic rand_inputs(input bit allow_over, input bit allow_fin);
        bus.game_plot   = 1'($urandom);
        bus.game_x      = 8'($urandom);
        bus.game_y      = 7'($urandom);
        bus.game_colour = 3'($urandom);
        bus.game_over   = allow_over ? 1'($urandom) : 1'b0;
        bus.end_plot    = 1'($urandom);
        bus.end_x       = 8'($urandom);
        bus.end_y       = 7'($urandom);
        bus.end_colour  = 3'($urandom);
        bus.end_finish  = allow_fin ? 1'($urandom) : 1'b0;
    endtask

    task automatic run(input int n, input bit allow_over, input bit allow_fin);
        for (int i = 0; i < n; i++) begin
            rand_inputs(allow_over, allow_fin);
            cycle();
        end
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        #2;
        model_reset();
        check_outputs();
        @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        int clear_cnt;
        n_cmp = 0; n_err = 0;
        resetn = 1'b1;
        rand_inputs(1'b0, 1'b0);
        #3;
        apply_reset();

        // Directed game pixel.
        bus.game_plot = 1'b1; bus.game_x = 8'd10; bus.game_y = 7'd20; bus.game_colour = 3'b101;
        cycle();
        chk("t1_x", int'(bus.vga_x), 10);
        chk("t1_y", int'(bus.vga_y), 20);
        run(40, 1'b0, 1'b0);

        // Game over pulse followed by the full blanking sweep under random noise.
        rand_inputs(1'b0, 1'b0);
        bus.game_over = 1'b1;
        cycle();
        clear_cnt = 0;
        for (int i = 0; i < W * H; i++) begin
            rand_inputs(1'b1, 1'b1);
            cycle();
            if (bus.vga_plot === 1'b1 && bus.vga_colour === 3'd0) clear_cnt++;
            if (i == 0)         chk("first_xy", int'({bus.vga_x, bus.vga_y}), 0);
            if (i == W)         chk("row1_y", int'(bus.vga_y), 1);
            if (i == W * H - 1) chk("last_xy", int'({bus.vga_x, bus.vga_y}), (159 << 7) | 119);
        end
        chk("clear_plots", clear_cnt, W * H);

        // End screen: drawer pixels pass through, game pixels do not.
        run(30, 1'b1, 1'b0);
        chk("endscr_en", int'(bus.end_en), 1);
        rand_inputs(1'b1, 1'b0);
        bus.end_plot = 1'b1; bus.end_x = 8'd40; bus.end_y = 7'd40; bus.end_colour = 3'b011;
        cycle();
        chk("t3_colour", int'(bus.vga_colour), 3);
        rand_inputs(1'b1, 1'b0);
        bus.end_plot = 1'b1; bus.end_finish = 1'b1;
        cycle();
        chk("t4_done", int'(bus.done), 1);
        run(10, 1'b1, 1'b1);

        // Reset in the middle of a sweep, then restart.
        apply_reset();
        run(10, 1'b0, 1'b0);
        rand_inputs(1'b0, 1'b0);
        bus.game_over = 1'b1;
        cycle();
        run(5000, 1'b1, 1'b1);
        apply_reset();
        chk("mid_reset_plot", int'(bus.vga_plot), 0);

        // Game over coinciding with a game pixel; drawer already finished on entry.
        rand_inputs(1'b0, 1'b0);
        bus.game_over = 1'b1; bus.game_plot = 1'b1;
        bus.game_x = 8'd5; bus.game_y = 7'd6; bus.game_colour = 3'b111;
        cycle();
        chk("t6_x", int'(bus.vga_x), 5);
        chk("t6_colour", int'(bus.vga_colour), 7);
        for (int i = 0; i < W * H + 10 && m_mode == 1; i++) begin
            rand_inputs(1'b1, 1'b0);
            bus.end_finish = 1'b1;
            cycle();
            if (i == 0) chk("t6_restart_xy", int'({bus.vga_plot, bus.vga_x, bus.vga_y}), 1 << 15);
        end
        chk("sweep_bound", m_mode, 2);
        for (int i = 0; i < 4; i++) begin
            rand_inputs(1'b1, 1'b0);
            bus.end_finish = 1'b1;
            cycle();
        end
        chk("final_done", int'(bus.done), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
